// File: rtl/pulse_receiver.sv
// Pulse-width receiver: times alternating sig_in levels in prescaled ticks and
// queues {level, duration} records in a small show-ahead FIFO.
module pulse_receiver #(
  parameter int unsigned DUR_W      = 15,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
  input  logic [7:0]                   prescale,
  input  logic [DUR_W-1:0]             timeout,
  input  logic                         sig_in,
  input  logic                         rd_en,
  output logic [DUR_W:0]               rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overflow,
  output logic                         busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = DUR_W + 1;

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  state_t           state, state_d;
  logic             sync1, sync2, sig_dly;
  logic [7:0]       pcnt, pcnt_d, pcnt_eff;
  logic [DUR_W-1:0] dur, dur_d, dur_base;
  logic             edge_c, fall_c, tick_c, tmo_c;
  logic             push_c, pop_c, wr_ok_c, ovf_set_c;
  logic [RW-1:0]    push_data;
  logic [RW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]    count_d;
  logic [RW-1:0]    head_d;

  // Edge detect, prescaler and duration counter; the edge cycle is tick-counted
  // as the first cycle of the new level so a level of L cycles yields L/(p+1).
  always_comb begin
    edge_c   = sync2 ^ sig_dly;
    fall_c   = edge_c & ~sync2;
    pcnt_eff = edge_c ? 8'd0 : pcnt;
    tick_c   = (pcnt_eff == prescale);
    pcnt_d   = tick_c ? 8'd0 : pcnt_eff + 8'd1;
    dur_base = edge_c ? '0 : dur;
    dur_d    = (tick_c && (dur_base != '1)) ? dur_base + DUR_W'(1) : dur_base;
    tmo_c    = (state == MEASURE) && !edge_c && sig_dly &&
               (timeout != '0) && (dur == timeout);
  end

  // Next state and record push
  always_comb begin
    state_d   = state;
    push_c    = 1'b0;
    push_data = '0;
    if (clr || !en) begin
      state_d = IDLE;
    end else if (state == IDLE) begin
      if (fall_c) state_d = MEASURE;
    end else if (edge_c) begin
      push_c    = 1'b1;
      push_data = {sig_dly, dur};
    end else if (tmo_c) begin
      push_c    = 1'b1;
      push_data = {1'b1, timeout};
      state_d   = IDLE;
    end
  end

  // FIFO bookkeeping; head_d precomputes the registered show-ahead output
  always_comb begin
    pop_c     = rd_en && !empty && !clr;
    wr_ok_c   = push_c && (!full || pop_c);
    ovf_set_c = push_c && full && !pop_c;
    wr_ptr_d  = wr_ok_c ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_d  = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    count_d   = count;
    if (wr_ok_c && !pop_c)      count_d = count + CW'(1);
    else if (!wr_ok_c && pop_c) count_d = count - CW'(1);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    if (count_d == '0)                         head_d = '0;
    else if (wr_ok_c && (wr_ptr == rd_ptr_d))  head_d = push_data;
    else                                       head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      sig_dly  <= 1'b1;
      pcnt     <= '0;
      dur      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      sync1    <= sig_in;
      sync2    <= sync1;
      sig_dly  <= sync2;
      pcnt     <= pcnt_d;
      dur      <= dur_d;
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      count    <= count_d;
      rd_data  <= head_d;
      empty    <= (count_d == '0);
      full     <= (count_d == CW'(FIFO_DEPTH));
      overflow <= clr ? 1'b0 : (overflow | ovf_set_c);
      busy     <= (state_d == MEASURE);
    end
  end

  // Record storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_ok_c && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_pulse_receiver.sv
// Directed bench for pulse_receiver with hand-computed record values.
module tb_pulse_receiver;

  localparam int unsigned DUR_W = 15;
  localparam logic [31:0] HI = 32'h8000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic [7:0]        prescale = 8'd0;
  logic [DUR_W-1:0]  timeout = '0;
  logic              sig_in = 1'b1;
  logic              rd_en = 1'b0;
  logic [DUR_W:0]    rd_data;
  logic              empty, full, overflow, busy;
  logic [2:0]        count;

  int total = 0;
  int bad   = 0;

  pulse_receiver #(.DUR_W(DUR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .prescale(prescale),
    .timeout(timeout), .sig_in(sig_in), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    check(tag, 32'(rd_data), exp);
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
  endtask

  initial begin
    wait_cyc(2);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    en = 1'b1;
    timeout = 15'd100;
    wait_cyc(5);

    // basic frame ending in a timeout
    sig_in = 1'b0; wait_cyc(10);
    check("f1_busy", 32'(busy), 1);
    sig_in = 1'b1; wait_cyc(20);
    sig_in = 1'b0; wait_cyc(5);
    sig_in = 1'b1; wait_cyc(90);
    check("f1_busy_pre_tmo", 32'(busy), 1);
    check("f1_count_pre_tmo", 32'(count), 3);
    wait_cyc(20);
    check("f1_busy_post_tmo", 32'(busy), 0);
    check("f1_count", 32'(count), 4);
    pop_chk("f1_r0", 32'd10);
    pop_chk("f1_r1", HI | 32'd20);
    pop_chk("f1_r2", 32'd5);
    pop_chk("f1_r3", HI | 32'd100);
    check("f1_empty", 32'(empty), 1);

    // prescaled frame, no timeout
    prescale = 8'd3;
    timeout = '0;
    wait_cyc(3);
    sig_in = 1'b0; wait_cyc(40);
    sig_in = 1'b1; wait_cyc(80);
    sig_in = 1'b0; wait_cyc(8);
    check("f2_count", 32'(count), 2);
    check("f2_busy", 32'(busy), 1);
    pop_chk("f2_r0", 32'd10);
    pop_chk("f2_r1", HI | 32'd20);
    pulse_clr();
    check("f2_busy_clr", 32'(busy), 0);
    sig_in = 1'b1; wait_cyc(5);

    // overflow with six pulses
    prescale = 8'd0;
    for (int i = 0; i < 6; i++) begin
      sig_in = 1'b0; wait_cyc(3 + i);
      sig_in = 1'b1; wait_cyc(4);
    end
    wait_cyc(4);
    check("ovf_full", 32'(full), 1);
    check("ovf_count", 32'(count), 4);
    check("ovf_flag", 32'(overflow), 1);
    pop_chk("ovf_r0", 32'd3);
    pop_chk("ovf_r1", HI | 32'd4);
    pop_chk("ovf_r2", 32'd4);
    pop_chk("ovf_r3", HI | 32'd4);
    check("ovf_sticky", 32'(overflow), 1);
    pulse_clr();
    check("clr_empty", 32'(empty), 1);
    check("clr_ovf", 32'(overflow), 0);

    // push and pop together while full
    sig_in = 1'b0; wait_cyc(3);
    sig_in = 1'b1; wait_cyc(4);
    sig_in = 1'b0; wait_cyc(5);
    sig_in = 1'b1; wait_cyc(6);
    sig_in = 1'b0; wait_cyc(7);
    check("pp_full_before", 32'(full), 1);
    check("pp_head_before", 32'(rd_data), 3);
    sig_in = 1'b1; wait_cyc(2);
    rd_en = 1'b1; wait_cyc(1);
    rd_en = 1'b0;
    check("pp_count", 32'(count), 4);
    check("pp_ovf", 32'(overflow), 0);
    pop_chk("pp_r0", HI | 32'd4);
    pop_chk("pp_r1", 32'd5);
    pop_chk("pp_r2", HI | 32'd6);
    pop_chk("pp_r3", 32'd7);
    check("pp_empty", 32'(empty), 1);

    // read while empty is ignored
    rd_en = 1'b1; wait_cyc(1);
    rd_en = 1'b0;
    check("rde_count", 32'(count), 0);
    check("rde_data", 32'(rd_data), 0);
    pulse_clr();

    // saturation and edge-to-count latency
    sig_in = 1'b0; wait_cyc(33000);
    sig_in = 1'b1; wait_cyc(2);
    check("lat_n2", 32'(count), 0);
    wait_cyc(1);
    check("lat_n3", 32'(count), 1);
    check("sat_rec", 32'(rd_data), 32'd32767);

    // en low mid-frame discards the level
    wait_cyc(3);
    en = 1'b0; wait_cyc(1);
    check("en_busy", 32'(busy), 0);
    sig_in = 1'b0; wait_cyc(4);
    en = 1'b1;
    sig_in = 1'b1; wait_cyc(5);
    check("en_count", 32'(count), 1);
    check("en_idle", 32'(busy), 0);

    // async reset mid-frame
    sig_in = 1'b0; wait_cyc(5);
    check("mr_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mr_rd_data", 32'(rd_data), 0);
    check("mr_empty", 32'(empty), 1);
    check("mr_count", 32'(count), 0);
    check("mr_busy0", 32'(busy), 0);
    check("mr_full", 32'(full), 0);
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(6);
    sig_in = 1'b1; wait_cyc(4);
    check("mr_new_count", 32'(count), 1);
    check("mr_new_rec", 32'(rd_data), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
